// File: rtl/spi_req_arb_pkg.sv
// Shared types and helpers for the SPI request arbiter.
package spi_req_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StXfer,
        StDone
    } arb_state_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping to 0.
module spi_rr_arbiter import spi_req_arb_pkg::*; #(
    parameter int unsigned NCH = 4,
    parameter int unsigned IW  = idx_width(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx,
    output logic           vld
);

    logic [IW:0]    sh;
    logic [IW:0]    pos;
    logic [NCH-1:0] rot;

    always_comb begin
        sh  = {1'b0, ptr} + (IW+1)'(1);
        // rot[j] is the request of channel (ptr + 1 + j) mod NCH
        rot = NCH'({req, req} >> sh);
        pos = '0;
        idx = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pos = sh + (IW+1)'(j);
                if (pos >= (IW+1)'(NCH)) begin
                    pos = pos - (IW+1)'(NCH);
                end
                idx = pos[IW-1:0];
            end
        end
        vld = |req;
        gnt = vld ? (NCH'(1) << idx) : '0;
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// N-channel round-robin arbiter in front of a single SPI flash controller.
// Define SPI_REQ_ARB_WATCHDOG_EN to abort transfers stuck in XFER for TO_CYCLES cycles.
module spi_req_arbiter import spi_req_arb_pkg::*; #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned CSIZE     = 3,
    parameter int unsigned LSIZE     = 24,
    parameter int unsigned TO_CYCLES = 65535
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic [NCH-1:0]       m_request,
    input  logic [NCH*CSIZE-1:0] m_req_cmd,
    input  logic [NCH*LSIZE-1:0] m_req_len,
    input  logic [NCH*LSIZE-1:0] m_req_wr_len,
    output logic [NCH-1:0]       m_busy,
    output logic [NCH-1:0]       m_finish,
    output logic [NCH-1:0]       m_err,
    input  logic [NCH-1:0]       m_wr_vld,
    input  logic [NCH*DSIZE-1:0] m_wr_data,
    output logic [NCH-1:0]       m_wr_ready,
    output logic [NCH-1:0]       m_wr_last,
    input  logic [NCH-1:0]       m_rd_ready,
    output logic [NCH-1:0]       m_rd_vld,
    output logic [DSIZE-1:0]     m_rd_data,
    output logic [NCH-1:0]       m_rd_last,
    output logic                 s_request,
    output logic [CSIZE-1:0]     s_req_cmd,
    output logic [LSIZE-1:0]     s_req_len,
    output logic [LSIZE-1:0]     s_req_wr_len,
    input  logic                 s_busy,
    input  logic                 s_finish,
    output logic                 s_wr_vld,
    output logic [DSIZE-1:0]     s_wr_data,
    input  logic                 s_wr_ready,
    input  logic                 s_wr_last,
    output logic                 s_rd_ready,
    input  logic                 s_rd_vld,
    input  logic [DSIZE-1:0]     s_rd_data,
    input  logic                 s_rd_last
);

    localparam int unsigned IW = idx_width(NCH);

    arb_state_e     state_q;
    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  gnt_q;
    logic [IW-1:0]  arb_idx;
    logic [NCH-1:0] arb_gnt;
    logic           arb_vld;
    logic [CSIZE-1:0] sel_cmd;
    logic [LSIZE-1:0] sel_len;
    logic [LSIZE-1:0] sel_wr_len;
    logic           in_xfer;
    logic           timeout;

    // Controller busy carries no information the FSM needs beyond s_finish.
    logic unused_busy;
    assign unused_busy = s_busy;

    spi_rr_arbiter #(
        .NCH (NCH),
        .IW  (IW)
    ) u_rr (
        .req (m_request),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    always_comb begin
        sel_cmd    = '0;
        sel_len    = '0;
        sel_wr_len = '0;
        for (int i = 0; i < NCH; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_cmd    = m_req_cmd[i*CSIZE +: CSIZE];
                sel_len    = m_req_len[i*LSIZE +: LSIZE];
                sel_wr_len = m_req_wr_len[i*LSIZE +: LSIZE];
            end
        end
    end

`ifdef SPI_REQ_ARB_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(TO_CYCLES + 1);

    logic [WDW-1:0] wd_cnt;

    assign timeout = (wd_cnt == WDW'(TO_CYCLES - 1));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            m_err  <= '0;
        end else if (clk_en) begin
            m_err <= '0;
            if (state_q == StIssue) begin
                wd_cnt <= '0;
            end else if (state_q == StXfer) begin
                wd_cnt <= wd_cnt + WDW'(1);
                // A real finish on the timeout cycle wins over the error.
                if (timeout && !s_finish) begin
                    m_err <= m_busy;
                end
            end
        end
    end
`else
    logic unused_to;
    assign unused_to = TO_CYCLES[0];
    assign timeout   = 1'b0;
    assign m_err     = '0;
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= IW'(NCH - 1);
            gnt_q        <= '0;
            s_request    <= 1'b0;
            s_req_cmd    <= '0;
            s_req_len    <= '0;
            s_req_wr_len <= '0;
            m_busy       <= '0;
            m_finish     <= '0;
        end else if (clk_en) begin
            s_request <= 1'b0;
            m_finish  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (arb_vld) begin
                        gnt_q        <= arb_idx;
                        s_req_cmd    <= sel_cmd;
                        s_req_len    <= sel_len;
                        s_req_wr_len <= sel_wr_len;
                        s_request    <= 1'b1;
                        m_busy       <= arb_gnt;
                        state_q      <= StIssue;
                    end
                end
                StIssue: state_q <= StXfer;
                StXfer: begin
                    if (s_finish || timeout) begin
                        m_finish <= m_busy;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    m_busy  <= '0;
                    ptr_q   <= gnt_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_xfer   = (state_q == StXfer);
    assign m_rd_data = in_xfer ? s_rd_data : '0;

    always_comb begin
        s_wr_vld   = 1'b0;
        s_wr_data  = '0;
        s_rd_ready = 1'b0;
        m_wr_ready = '0;
        m_wr_last  = '0;
        m_rd_vld   = '0;
        m_rd_last  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (in_xfer && gnt_q == IW'(i)) begin
                s_wr_vld      = m_wr_vld[i];
                s_wr_data     = m_wr_data[i*DSIZE +: DSIZE];
                s_rd_ready    = m_rd_ready[i];
                m_wr_ready[i] = s_wr_ready;
                m_wr_last[i]  = s_wr_last;
                m_rd_vld[i]   = s_rd_vld;
                m_rd_last[i]  = s_rd_last;
            end
        end
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_spi_req_arbiter;

    localparam int NCH   = 4;
    localparam int DSIZE = 8;
    localparam int CSIZE = 3;
    localparam int LSIZE = 24;
    localparam int TO    = 10;

    logic                 clock;
    logic                 rst;
    logic                 clk_en;
    logic [NCH-1:0]       m_request;
    logic [NCH*CSIZE-1:0] m_req_cmd;
    logic [NCH*LSIZE-1:0] m_req_len;
    logic [NCH*LSIZE-1:0] m_req_wr_len;
    logic [NCH-1:0]       m_busy;
    logic [NCH-1:0]       m_finish;
    logic [NCH-1:0]       m_err;
    logic [NCH-1:0]       m_wr_vld;
    logic [NCH*DSIZE-1:0] m_wr_data;
    logic [NCH-1:0]       m_wr_ready;
    logic [NCH-1:0]       m_wr_last;
    logic [NCH-1:0]       m_rd_ready;
    logic [NCH-1:0]       m_rd_vld;
    logic [DSIZE-1:0]     m_rd_data;
    logic [NCH-1:0]       m_rd_last;
    logic                 s_request;
    logic [CSIZE-1:0]     s_req_cmd;
    logic [LSIZE-1:0]     s_req_len;
    logic [LSIZE-1:0]     s_req_wr_len;
    logic                 s_busy;
    logic                 s_finish;
    logic                 s_wr_vld;
    logic [DSIZE-1:0]     s_wr_data;
    logic                 s_wr_ready;
    logic                 s_wr_last;
    logic                 s_rd_ready;
    logic                 s_rd_vld;
    logic [DSIZE-1:0]     s_rd_data;
    logic                 s_rd_last;

    spi_req_arbiter #(
        .NCH       (NCH),
        .DSIZE     (DSIZE),
        .CSIZE     (CSIZE),
        .LSIZE     (LSIZE),
        .TO_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .clk_en       (clk_en),
        .m_request    (m_request),
        .m_req_cmd    (m_req_cmd),
        .m_req_len    (m_req_len),
        .m_req_wr_len (m_req_wr_len),
        .m_busy       (m_busy),
        .m_finish     (m_finish),
        .m_err        (m_err),
        .m_wr_vld     (m_wr_vld),
        .m_wr_data    (m_wr_data),
        .m_wr_ready   (m_wr_ready),
        .m_wr_last    (m_wr_last),
        .m_rd_ready   (m_rd_ready),
        .m_rd_vld     (m_rd_vld),
        .m_rd_data    (m_rd_data),
        .m_rd_last    (m_rd_last),
        .s_request    (s_request),
        .s_req_cmd    (s_req_cmd),
        .s_req_len    (s_req_len),
        .s_req_wr_len (s_req_wr_len),
        .s_busy       (s_busy),
        .s_finish     (s_finish),
        .s_wr_vld     (s_wr_vld),
        .s_wr_data    (s_wr_data),
        .s_wr_ready   (s_wr_ready),
        .s_wr_last    (s_wr_last),
        .s_rd_ready   (s_rd_ready),
        .s_rd_vld     (s_rd_vld),
        .s_rd_data    (s_rd_data),
        .s_rd_last    (s_rd_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction phase: 0 waiting for a grant, 1 request cycle, 2 streaming, 3 completion.
    int               ph;
    int               own;
    int               last_win;
    int               xfer_cycles;
    bit               e_err;
    logic [CSIZE-1:0] e_cmd;
    logic [LSIZE-1:0] e_len;
    logic [LSIZE-1:0] e_wl;

    // Round robin: first requesting channel after the previous winner.
    function automatic int next_owner(input logic [NCH-1:0] req, input int prev);
        int c;
        int w;
        w = -1;
        for (int k = NCH; k >= 1; k--) begin
            c = (prev + k) % NCH;
            if (req[c]) w = c;
        end
        return w;
    endfunction

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            ph          <= 0;
            own         <= 0;
            last_win    <= NCH - 1;
            xfer_cycles <= 0;
            e_err       <= 1'b0;
            e_cmd       <= '0;
            e_len       <= '0;
            e_wl        <= '0;
        end else if (clk_en) begin
            case (ph)
                0: begin
                    if (next_owner(m_request, last_win) >= 0) begin
                        own   <= next_owner(m_request, last_win);
                        e_cmd <= m_req_cmd[next_owner(m_request, last_win)*CSIZE +: CSIZE];
                        e_len <= m_req_len[next_owner(m_request, last_win)*LSIZE +: LSIZE];
                        e_wl  <= m_req_wr_len[next_owner(m_request, last_win)*LSIZE +: LSIZE];
                        ph    <= 1;
                    end
                end
                1: begin
                    ph          <= 2;
                    xfer_cycles <= 0;
                end
                2: begin
                    xfer_cycles <= xfer_cycles + 1;
                    if (s_finish) begin
                        ph <= 3;
                    end
`ifdef SPI_REQ_ARB_WATCHDOG_EN
                    else if (xfer_cycles + 1 == TO) begin
                        ph    <= 3;
                        e_err <= 1'b1;
                    end
`endif
                end
                default: begin
                    last_win <= own;
                    e_err    <= 1'b0;
                    ph       <= 0;
                end
            endcase
        end
    end

    // Compare every cycle, mid-period.
    always @(negedge clock) begin : cmp
        logic [NCH-1:0]   oh;
        logic [NCH-1:0]   x_wrdy, x_wlast, x_rvld, x_rlast;
        logic             x_swv, x_srr;
        logic [DSIZE-1:0] x_swd, x_rdd;
        oh      = (ph != 0) ? (NCH'(1) << own) : '0;
        x_wrdy  = '0;
        x_wlast = '0;
        x_rvld  = '0;
        x_rlast = '0;
        x_swv   = 1'b0;
        x_srr   = 1'b0;
        x_swd   = '0;
        x_rdd   = '0;
        if (ph == 2) begin
            x_wrdy[own]  = s_wr_ready;
            x_wlast[own] = s_wr_last;
            x_rvld[own]  = s_rd_vld;
            x_rlast[own] = s_rd_last;
            x_swv        = m_wr_vld[own];
            x_srr        = m_rd_ready[own];
            x_swd        = m_wr_data[own*DSIZE +: DSIZE];
            x_rdd        = s_rd_data;
        end
        chk("m_busy", m_busy, oh);
        chk("m_finish", m_finish, (ph == 3) ? oh : '0);
        chk("m_err", m_err, (ph == 3 && e_err) ? oh : '0);
        chk("s_request", s_request, (ph == 1) ? 1 : 0);
        chk("s_req_cmd", s_req_cmd, e_cmd);
        chk("s_req_len", s_req_len, e_len);
        chk("s_req_wr_len", s_req_wr_len, e_wl);
        chk("s_wr_vld", s_wr_vld, x_swv);
        chk("s_wr_data", s_wr_data, x_swd);
        chk("s_rd_ready", s_rd_ready, x_srr);
        chk("m_wr_ready", m_wr_ready, x_wrdy);
        chk("m_wr_last", m_wr_last, x_wlast);
        chk("m_rd_vld", m_rd_vld, x_rvld);
        chk("m_rd_last", m_rd_last, x_rlast);
        chk("m_rd_data", m_rd_data, x_rdd);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Advance until s_request is seen; expiry counts as a failed check.
    task automatic wait_grant(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            seen = s_request;
        end
        chk(name, seen, 1);
    endtask

    task automatic finish_xfer();
        tick();
        s_finish = 1'b1;
        tick();
        s_finish = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        clk_en       = 1'b1;
        m_request    = '0;
        m_req_cmd    = '0;
        m_req_len    = '0;
        m_req_wr_len = '0;
        m_wr_vld     = '0;
        m_wr_data    = '0;
        m_rd_ready   = '0;
        s_busy       = 1'b0;
        s_finish     = 1'b0;
        s_wr_ready   = 1'b0;
        s_wr_last    = 1'b0;
        s_rd_vld     = 1'b0;
        s_rd_data    = '0;
        s_rd_last    = 1'b0;
        repeat (2) tick();
        chk("reset_busy", m_busy, 0);
        chk("reset_s_request", s_request, 0);
        rst = 1'b0;

        // Single request on channel 2.
        m_request[2]                = 1'b1;
        m_req_cmd[2*CSIZE +: CSIZE] = 3'd3;
        m_req_len[2*LSIZE +: LSIZE] = 24'd16;
        m_req_wr_len[2*LSIZE +: LSIZE] = 24'd4;
        tick();
        chk("t1_s_request", s_request, 1);
        chk("t1_cmd", s_req_cmd, 3);
        chk("t1_len", s_req_len, 16);
        chk("t1_wr_len", s_req_wr_len, 4);
        chk("t1_busy", m_busy, 4'b0100);
        m_request[2] = 1'b0;
        tick();
        m_req_cmd[2*CSIZE +: CSIZE] = 3'd5;
        repeat (18) tick();
        chk("t1_cmd_stable", s_req_cmd, 3);
        s_finish = 1'b1;
        tick();
        s_finish = 1'b0;
        chk("t1_finish", m_finish, 4'b0100);
        chk("t1_busy_done", m_busy, 4'b0100);
        tick();
        chk("t1_finish_once", m_finish, 0);
        chk("t1_busy_idle", m_busy, 0);
        s_finish = 1'b1;
        tick();
        s_finish = 1'b0;
        chk("spurious_finish", m_finish, 0);
        chk("spurious_busy", m_busy, 0);

        // All four request from reset: grants 0,1,2,3.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        m_request = 4'b1111;
        for (int g = 0; g < NCH; g++) begin
            wait_grant("rr_grant_seen");
            chk("rr_order", m_busy, 32'(1) << g);
            m_request[g] = 1'b0;
            if (g == 1) begin
                tick();
                m_wr_vld   = 4'b0011;
                m_wr_data  = 32'h0000_55AA;
                s_wr_ready = 1'b1;
                s_rd_vld   = 1'b1;
                s_rd_last  = 1'b1;
                s_rd_data  = 8'h3C;
                m_rd_ready = 4'b1111;
                #1;
                chk("iso_wr_data", s_wr_data, 8'h55);
                chk("iso_wr_ready", m_wr_ready, 4'b0010);
                chk("iso_rd_vld", m_rd_vld, 4'b0010);
                chk("iso_rd_last", m_rd_last, 4'b0010);
                tick();
                chk("iso_wr_ready0", m_wr_ready[0], 0);
                m_wr_vld   = '0;
                m_wr_data  = '0;
                s_wr_ready = 1'b0;
                s_rd_vld   = 1'b0;
                s_rd_last  = 1'b0;
                m_rd_ready = '0;
            end
            finish_xfer();
        end

        // Finish and a new request in the same cycle.
        m_request[1] = 1'b1;
        wait_grant("sim_grant1");
        chk("sim_busy1", m_busy, 4'b0010);
        m_request[1] = 1'b0;
        tick();
        s_finish     = 1'b1;
        m_request[3] = 1'b1;
        tick();
        s_finish = 1'b0;
        chk("sim_finish", m_finish, 4'b0010);
        chk("sim_no_req", s_request, 0);
        tick();
        chk("sim_idle_finish", m_finish, 0);
        chk("sim_idle_req", s_request, 0);
        tick();
        chk("sim_req3", s_request, 1);
        chk("sim_busy3", m_busy, 4'b1000);
        m_request[3] = 1'b0;

        // Freeze with clk_en low in XFER, then reset mid-transfer.
        tick();
        clk_en   = 1'b0;
        s_finish = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("freeze_busy", m_busy, 4'b1000);
            chk("freeze_finish", m_finish, 0);
        end
        s_finish = 1'b0;
        clk_en   = 1'b1;
        tick();
        m_request = 4'b1001;
        rst       = 1'b1;
        #1;
        chk("rst_busy", m_busy, 0);
        chk("rst_len", s_req_len, 0);
        tick();
        chk("rst_finish", m_finish, 0);
        rst = 1'b0;
        wait_grant("post_rst_grant");
        chk("post_rst_ch0", m_busy, 4'b0001);
        m_request = '0;
        finish_xfer();

`ifdef SPI_REQ_ARB_WATCHDOG_EN
        m_request[2] = 1'b1;
        wait_grant("wd_grant");
        m_request[2] = 1'b0;
        tick();
        repeat (9) tick();
        chk("wd_no_err_yet", m_err, 0);
        tick();
        chk("wd_err", m_err, 4'b0100);
        chk("wd_finish", m_finish, 4'b0100);
        tick();
        m_request[3] = 1'b1;
        wait_grant("wd_grant2");
        m_request[3] = 1'b0;
        tick();
        repeat (9) tick();
        s_finish = 1'b1;
        tick();
        s_finish = 1'b0;
        chk("wd_fin_prio_err", m_err, 0);
        chk("wd_fin_prio_fin", m_finish, 4'b1000);
        tick();
`endif

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            rst    = ($urandom_range(0, 399) == 0);
            clk_en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NCH; i++) begin
                if (m_busy[i]) m_request[i] = 1'b0;
                else if (!m_request[i] && $urandom_range(0, 3) == 0) m_request[i] = 1'b1;
                m_req_cmd[i*CSIZE +: CSIZE]    = CSIZE'($urandom);
                m_req_len[i*LSIZE +: LSIZE]    = LSIZE'($urandom);
                m_req_wr_len[i*LSIZE +: LSIZE] = LSIZE'($urandom);
            end
            m_wr_vld   = NCH'($urandom);
            m_wr_data  = $urandom;
            m_rd_ready = NCH'($urandom);
            s_busy     = 1'($urandom);
            s_finish   = ($urandom_range(0, 5) == 0);
            s_wr_ready = 1'($urandom);
            s_wr_last  = 1'($urandom);
            s_rd_vld   = 1'($urandom);
            s_rd_last  = 1'($urandom);
            s_rd_data  = DSIZE'($urandom);
        end
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- N-channel arbiter for the SPI request protocol: request/cmd/len, busy/finish, write stream, read stream.
- Multiplexes N independent master-side request ports onto one slave port feeding the single SPI flash controller.
- Round-robin grant per transaction.
- Once a channel is granted, the write and read streams are routed to it until the controller signals finish.

Parameters:
- NCH, 4, number of master channels (2..16)
- DSIZE, 8, stream data width
- CSIZE, 3, command width
- LSIZE, 24, width of req_len / req_wr_len
- TO_CYCLES, 65535, watchdog limit (used only with optional feature)

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- clk_en  in  1  clock qualifier; state advances only when 1
- m_request  in  NCH  per-channel request level
- m_req_cmd  in  NCH*CSIZE  per-channel command
- m_req_len  in  NCH*LSIZE  per-channel total length
- m_req_wr_len  in  NCH*LSIZE  per-channel write length
- m_busy  out  NCH  channel i currently granted
- m_finish  out  NCH  one-cycle done pulse to granted channel
- m_err  out  NCH  one-cycle watchdog pulse (optional feature)
- m_wr_vld  in  NCH  write valid
- m_wr_data  in  NCH*DSIZE  write data
- m_wr_ready  out  NCH  write ready
- m_wr_last  out  NCH  write last
- m_rd_ready  in  NCH  read ready
- m_rd_vld  out  NCH  read valid
- m_rd_data  out  DSIZE  read data, broadcast to all channels
- m_rd_last  out  NCH  read last
- s_request  out  1  request pulse to controller
- s_req_cmd  out  CSIZE  latched command
- s_req_len  out  LSIZE  latched length
- s_req_wr_len  out  LSIZE  latched write length
- s_busy  in  1  controller busy
- s_finish  in  1  controller done pulse
- s_wr_vld, s_wr_data, s_wr_ready, s_wr_last  out/out/in/in  1/DSIZE/1/1  write stream to controller
- s_rd_ready, s_rd_vld, s_rd_data, s_rd_last  out/in/in/in  1/1/DSIZE/1  read stream from controller

Behaviour:
- All sequential updates gated by clk_en; with clk_en=0, all registers hold.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - RR pointer = NCH-1, so channel 0 wins first.
  - Grant index 0.
- States: IDLE -> ISSUE -> XFER -> DONE -> IDLE.
- IDLE:
  - If any m_request bit is set, spi_rr_arbiter picks the first requester after the pointer, wrapping NCH-1 -> 0.
  - Latch grant index g and that channel's cmd/len/wr_len into s_req_*, then go to ISSUE.
- ISSUE:
  - s_request=1 for exactly one cycle.
  - m_busy[g]=1 from here through DONE inclusive.
  - Next state XFER.
- XFER:
  - Streams routed combinationally:
    - s_wr_vld=m_wr_vld[g], s_wr_data=m_wr_data[g].
    - m_wr_ready[g]=s_wr_ready, m_wr_last[g]=s_wr_last.
    - m_rd_vld[g]=s_rd_vld, m_rd_last[g]=s_rd_last, s_rd_ready=m_rd_ready[g].
  - Non-granted channels see ready/vld/last=0.
  - Exit to DONE on s_finish=1.
- DONE:
  - m_finish[g]=1 for one cycle.
  - Pointer := g; go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0 -> s_request at cycle 1.
  - s_finish at cycle k -> m_finish[g] at k+1.
  - Next grant is possible at k+2 (s_request at k+3).
- Requests are sampled only in IDLE:
  - Masters hold m_request until their m_busy bit rises, then drop it.
  - A request still high in DONE/IDLE after m_finish is treated as a new transaction.
- s_finish outside XFER is ignored.
- A new request arriving in the same cycle as s_finish waits for the IDLE cycle.
- s_req_* are stable from ISSUE until the next IDLE grant, regardless of master input changes.
- Lengths are passed unmodified; len=0 is forwarded, and completion relies only on s_finish.
- Asynchronous rst mid-transaction forces IDLE immediately and zeroes all outputs. The in-flight transaction gets no m_finish.

Optional Feature:
- Macro SPI_REQ_ARB_WATCHDOG_EN.
- When defined:
  - A counter (clog2(TO_CYCLES+1) bits) clears on entry to XFER and counts clk_en cycles in XFER.
  - On reaching TO_CYCLES without s_finish, go to DONE; m_finish[g] and m_err[g] pulse together.
  - s_finish in the same cycle as timeout takes priority (no m_err).
- When undefined: m_err tied 0, no counter, XFER waits indefinitely.

Decomposition:
- Package spi_req_arb_pkg: state enum (IDLE, ISSUE, XFER, DONE) and a clog2-based index-width function.
- Sub-module spi_rr_arbiter: NCH request vector + pointer -> one-hot grant + index, combinational, rotate-and-priority-encode.

Test Plan:
- Single request: ch2 request, cmd=3, len=16, wr_len=4.
  - Expect s_request at cycle 1 with s_req_cmd=3, len=16, wr_len=4, m_busy[2]=1.
  - s_finish at cycle 20 -> m_finish[2] at cycle 21.
- All four channels request simultaneously from reset -> grants in order 0,1,2,3, one transaction each.
- Stream isolation: ch1 granted, ch0 drives wr_vld=1 data 0xAA, ch1 drives 0x55.
  - s_wr_data=0x55 only.
  - m_wr_ready[0]=0 throughout.
  - Read beats reach m_rd_vld[1] only.
- Simultaneous events: s_finish in the same cycle ch3 raises request.
  - m_finish pulse next cycle, then IDLE, then s_request for ch3.
  - Spurious s_finish in IDLE produces no pulse.
- clk_en=0 held 5 cycles in XFER -> state/outputs frozen. Reset asserted in XFER -> all outputs 0, no m_finish, ch0 wins next.
- Watchdog (macro on, TO_CYCLES=10): no s_finish -> m_err[g] and m_finish[g] pulse 10 cycles after XFER entry. Repeat with s_finish on cycle 10 -> no m_err.
